alu_seq_16: RTL
===============

# alu_seq_16

Multi-cycle sequencer that performs WIDTH-bit operations on the team's 4-bit ALU datapath. It issues one 4-bit ALU pass per cycle, least-significant nibble first, and chains carry from pass to pass. It sits between a valid/ready command source and a valid/ready result sink. The 4-bit ALU is instantiated internally and is not shared outside this block.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4, minimum 4.
- NIBBLES, WIDTH/4, derived; not overridable.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  operation code (see Operation).
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_cin  in  1  carry-in for ADD; ignored by all other operations.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  sink accepts the result.
- rsp_y  out  WIDTH  result.
- rsp_cout  out  1  carry out of the top nibble for ADD/SUB; 0 for logic operations.
- rsp_zero  out  1  rsp_y == 0.
- rsp_ovf  out  1  signed overflow; present only with ALU_SEQ_OVF_EN.

## Operation
- Op codes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR
  - 100 ADD: A+B+cin
  - 101 SUB: A+~B+1; the initial carry is forced to 1 and cmd_cin is ignored
  - 110 PASSA, 111 PASSB
- The 4-bit ALU computes carry only for ADD/SUB. Logic ops produce Cout=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op, A, B and the initial carry; clear idx and result; go to EXEC.
- EXEC:
  - cmd_ready=0.
  - Drive the ALU with A[4*idx+:4], B[4*idx+:4] and the carry register.
  - Write the ALU Y into result[4*idx+:4]; carry <= Cout; idx <= idx+1.
  - At idx==NIBBLES-1, write the last nibble, capture cout (and the ovf inputs), then go to DONE.
- DONE:
  - rsp_valid=1; rsp_* are stable until the handshake.
  - On rsp_ready, go to IDLE.
  - No command is accepted in DONE.
- Overflow: sign(A)==sign(B') && sign(Y)!=sign(A), where B' is B for ADD and ~B for SUB. It is 0 for logic ops.
- idx width is clog2(NIBBLES), minimum 1. idx never exceeds NIBBLES-1; there is no wrap-around inside a command.
- Illegal states recover to IDLE.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1, rsp_valid=0
  - rsp_y=0, rsp_cout=0, rsp_zero=1, rsp_ovf=0
  - idx=0, carry=0
- Latency: command accepted at edge T → rsp_valid high after edge T+NIBBLES (4 cycles for WIDTH=16).
- Minimum spacing between accepts is NIBBLES+2 cycles (IDLE, NIBBLES×EXEC, DONE).
- rsp_ready is sampled only in DONE. rsp_ready held high gives a single-cycle rsp_valid pulse.
- cmd_valid asserted in EXEC/DONE has no effect; the source must hold it until the cycle with cmd_ready=1.
- Reset mid-EXEC or mid-DONE drops the command and returns all outputs to their reset values immediately.
- Outputs are registered. The ALU path is combinational inside one cycle.

## Configuration
- ALU_SEQ_OVF_EN defined:
  - Port rsp_ovf exists.
  - The sign bits of A, B' and Y are captured during the last EXEC cycle.
- ALU_SEQ_OVF_EN undefined:
  - No rsp_ovf port and no overflow logic.
  - All other behaviour is identical.

## Structure
- Package alu_seq_pkg holds:
  - op-code localparams (OP_AND … OP_PASSB)
  - state encoding (S_IDLE, S_EXEC, S_DONE)
  - ALU function width (3)
- One sub-module, alu_4bit: combinational 4-bit ALU, ports (Cin, A, B, Fin, Y, Cout), op codes as above.

## Test plan
- ADD A=0x00FF, B=0x0001, cin=0 → rsp_y=0x0100, cout=0, zero=0; rsp_valid rises exactly 4 cycles after accept.
- ADD A=0xFFFF, B=0x0001, cin=0 → rsp_y=0x0000, cout=1, zero=1; with ALU_SEQ_OVF_EN, ovf=0. ADD 0x7FFF+0x0001 → ovf=1.
- SUB A=0x0005, B=0x0007, cmd_cin=0 → rsp_y=0xFFFE, cout=0 (borrow).
- AND A=0xF0F0, B=0x3C3C → 0x3030, cout=0. NOR A=0x0000, B=0x000F → 0xFFF0.
- Backpressure: rsp_ready low for 3 cycles in DONE → rsp_y/cout/zero stable, cmd_ready=0, a pending cmd_valid is not accepted. rsp_ready high → IDLE next cycle, and the pending command is accepted in IDLE.
- Reset asserted in the 2nd EXEC cycle → rsp_valid=0, rsp_y=0, cmd_ready=1 without waiting for a clock. After release, a fresh ADD 0x1234+0x1111 → 0x2345.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared op codes, FSM encoding and helpers for alu_seq_16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam int ALU_FN_W = 3;

   localparam logic [ALU_FN_W-1:0] OP_AND   = 3'b000;
   localparam logic [ALU_FN_W-1:0] OP_OR    = 3'b001;
   localparam logic [ALU_FN_W-1:0] OP_XOR   = 3'b010;
   localparam logic [ALU_FN_W-1:0] OP_NOR   = 3'b011;
   localparam logic [ALU_FN_W-1:0] OP_ADD   = 3'b100;
   localparam logic [ALU_FN_W-1:0] OP_SUB   = 3'b101;
   localparam logic [ALU_FN_W-1:0] OP_PASSA = 3'b110;
   localparam logic [ALU_FN_W-1:0] OP_PASSB = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // SUB is A + ~B + 1, so its first carry is always 1; logic ops ignore carry.
   function automatic logic init_carry(input logic [ALU_FN_W-1:0] op, input logic cin);
      logic c;
      c = 1'b0;
      if (op == OP_ADD) c = cin;
      else if (op == OP_SUB) c = 1'b1;
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_16_if.sv
// ============================================================================
// Module      : alu_seq_16_if
// Description : Command/response valid-ready bundle for alu_seq_16.
//               rsp_ovf exists only when ALU_SEQ_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_16_if
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [ALU_FN_W-1:0] cmd_op;
   logic [WIDTH-1:0]    cmd_a;
   logic [WIDTH-1:0]    cmd_b;
   logic                cmd_cin;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [WIDTH-1:0]    rsp_y;
   logic                rsp_cout;
   logic                rsp_zero;
`ifdef ALU_SEQ_OVF_EN
   logic                rsp_ovf;
`endif

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_y, rsp_cout, rsp_zero
`ifdef ALU_SEQ_OVF_EN
      , input rsp_ovf
`endif
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
      output cmd_ready, rsp_valid, rsp_y, rsp_cout, rsp_zero
`ifdef ALU_SEQ_OVF_EN
      , output rsp_ovf
`endif
   );

endinterface

`default_nettype wire

// File: rtl/alu_4bit.sv
// ============================================================================
// Module      : alu_4bit
// Description : Combinational 4-bit ALU; carry-out only for ADD/SUB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_4bit
   import alu_seq_pkg::*;
(
   input  wire logic                Cin,
   input  wire logic [3:0]          A,
   input  wire logic [3:0]          B,
   input  wire logic [ALU_FN_W-1:0] Fin,
   output logic      [3:0]          Y,
   output logic                     Cout
);

   logic [4:0] w_sum;

   always_comb begin
      w_sum = 5'd0;
      Y     = 4'd0;
      Cout  = 1'b0;
      case (Fin)
         OP_AND:   Y = A & B;
         OP_OR:    Y = A | B;
         OP_XOR:   Y = A ^ B;
         OP_NOR:   Y = ~(A | B);
         OP_ADD: begin
            w_sum = {1'b0, A} + {1'b0, B} + {4'd0, Cin};
            Y     = w_sum[3:0];
            Cout  = w_sum[4];
         end
         OP_SUB: begin
            w_sum = {1'b0, A} + {1'b0, ~B} + {4'd0, Cin};
            Y     = w_sum[3:0];
            Cout  = w_sum[4];
         end
         OP_PASSA: Y = A;
         OP_PASSB: Y = B;
         default:  Y = 4'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq_16.sv
// ============================================================================
// Module      : alu_seq_16
// Description : Nibble-serial WIDTH-bit ALU sequencer (LSB nibble first).
//               Optional signed-overflow output under ALU_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_16
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  wire logic   clk,
   input  wire logic   rst,
   alu_seq_16_if.slave bus
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [IDX_W-1:0]    r_idx;
   logic [ALU_FN_W-1:0] r_op;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic                r_carry;
   logic [WIDTH-1:0]    r_result;
   logic                r_cout;
   logic                r_zero;

   logic                w_accept;
   logic                w_last;
   logic [3:0]          w_alu_y;
   logic                w_alu_cout;
   logic [WIDTH-1:0]    w_result_next;

   alu_4bit u_alu (
      .Cin  (r_carry),
      .A    (r_a[{r_idx, 2'b00} +: 4]),
      .B    (r_b[{r_idx, 2'b00} +: 4]),
      .Fin  (r_op),
      .Y    (w_alu_y),
      .Cout (w_alu_cout)
   );

   always_comb begin
      w_state_next  = r_state;
      w_accept      = 1'b0;
      w_last        = (r_idx == C_LAST_IDX);
      w_result_next = r_result;
      w_result_next[{r_idx, 2'b00} +: 4] = w_alu_y;
      case (r_state)
         S_IDLE: begin
            w_accept = bus.cmd_valid;
            if (bus.cmd_valid) w_state_next = S_EXEC;
         end
         S_EXEC: begin
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            if (bus.rsp_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx    <= '0;
         r_op     <= OP_AND;
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b1;
      end else if (w_accept) begin
         r_idx    <= '0;
         r_op     <= bus.cmd_op;
         r_a      <= bus.cmd_a;
         r_b      <= bus.cmd_b;
         r_carry  <= init_carry(bus.cmd_op, bus.cmd_cin);
         r_result <= '0;
      end else if (r_state == S_EXEC) begin
         r_result <= w_result_next;
         r_carry  <= w_alu_cout;
         // idx parks on the last nibble; the next accept clears it.
         if (w_last) begin
            r_cout <= w_alu_cout;
            r_zero <= (w_result_next == '0);
         end else begin
            r_idx  <= r_idx + 1'b1;
         end
      end
   end

`ifdef ALU_SEQ_OVF_EN
   logic r_ovf;
   logic w_bp_sign;
   logic w_arith;

   assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);
   assign w_bp_sign = (r_op == OP_SUB) ? ~r_b[WIDTH-1] : r_b[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if ((r_state == S_EXEC) && w_last) begin
         r_ovf <= w_arith && (r_a[WIDTH-1] == w_bp_sign) && (w_alu_y[3] != r_a[WIDTH-1]);
      end
   end

   assign bus.rsp_ovf = r_ovf;
`endif

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_DONE);
   assign bus.rsp_y     = r_result;
   assign bus.rsp_cout  = r_cout;
   assign bus.rsp_zero  = r_zero;

endmodule

`default_nettype wire
